csr_arb: RTL and testbench
==========================

CSR_ARB -- requirements
Module: csr_arb

Interface
REQ-001 Parameter NUM_REQ, default 2, number of CSR masters sharing the single CSR slave port (legal range 2..8).
REQ-002 Parameter TIMEOUT_CYC, default 64, watchdog limit in cycles; used only when CSR_ARB_TIMEOUT_EN is defined.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 m_wr  input  NUM_REQ  per-master write request.
REQ-006 m_rd  input  NUM_REQ  per-master read request.
REQ-007 m_addr  input  NUM_REQ x 32  per-master address.
REQ-008 m_wr_data  input  NUM_REQ x 32  per-master write data.
REQ-009 m_wait_rq  output  NUM_REQ  per-master stall; master holds its command stable while high.
REQ-010 m_rd_data  output  32  read data, broadcast to all masters, valid for the granted master on its completion cycle.
REQ-011 csr_wr, csr_rd  output  1 each  command to the CSR slave.
REQ-012 csr_addr, csr_wr_data  output  32 each  address and write data to the CSR slave.
REQ-013 csr_wait_rq  input  1  slave stall; a command completes in a cycle where it is asserted and csr_wait_rq is low.
REQ-014 csr_rd_data  input  32  slave read data, valid on the read completion cycle.
REQ-015 arb_err  output  1  sticky timeout flag (constant 0 without CSR_ARB_TIMEOUT_EN).

Function
REQ-016 The FSM SHALL have exactly the states IDLE and BUSY.
REQ-017 IDLE: requester i is any master with m_wr[i] or m_rd[i] high; if any exists, register grant = first requester at or after rr_ptr (wrapping NUM_REQ-1 -> 0) and go to BUSY next cycle.
REQ-018 IDLE: csr_wr = csr_rd = 0 and m_wait_rq[i] = 1 for every requesting master.
REQ-019 BUSY: csr_wr/csr_rd/csr_addr/csr_wr_data SHALL combinationally equal the granted master's signals.
REQ-020 If the granted master asserts both m_wr and m_rd, only csr_wr SHALL be forwarded.
REQ-021 BUSY: m_wait_rq[grant] = csr_wait_rq; every other requesting master sees m_wait_rq = 1.
REQ-022 Completion (BUSY, forwarded command high, csr_wait_rq low): m_rd_data = csr_rd_data that cycle; rr_ptr <= (grant+1) mod NUM_REQ; next state IDLE.
REQ-023 Minimum latency, request to completion: 2 cycles (1 arbitration bubble plus 1 slave cycle); back-to-back grants have one IDLE cycle between them.
REQ-024 If the granted master drops both m_wr and m_rd in BUSY, the FSM SHALL return to IDLE without advancing rr_ptr and without forwarding a command that cycle.
REQ-025 A non-requesting master SHALL see m_wait_rq = 0.
REQ-026 m_rd_data SHALL be 0 in every cycle other than a read completion.

Reset
REQ-027 On reset, state = IDLE, grant = 0, rr_ptr = 0, arb_err = 0, and the timeout counter = 0.
REQ-028 Reset asserted mid-transaction SHALL immediately drop csr_wr/csr_rd; the transaction is abandoned and is not replayed.

Configuration
REQ-029 Macro CSR_ARB_TIMEOUT_EN defined: a counter clears on entry to BUSY and increments each BUSY cycle in which csr_wait_rq is high.
REQ-030 When that counter reaches TIMEOUT_CYC-1 with csr_wait_rq still high, the arbiter SHALL force completion: m_wait_rq[grant] = 0, m_rd_data = 32'hDEAD_BEEF on a read, arb_err set (sticky until reset), rr_ptr advance, return to IDLE.
REQ-031 Macro undefined: no counter logic, arb_err tied 0, and BUSY lasts until the slave completes.

Structure
REQ-032 Shared package dma_pkg SHALL hold the arb_state_t enum (IDLE, BUSY), CSR_ADDR_W = 32, CSR_DATA_W = 32 and CSR_TIMEOUT_DATA = 32'hDEAD_BEEF.
REQ-033 Sub-module rr_pick SHALL be a combinational round-robin priority picker: inputs are the request vector and the pointer; outputs are the grant index and an any-request flag.

Verification
REQ-034 Single write: m_wr[0]=1, addr 0x10, data 0xA5A5_0001, slave wait 0 -> csr_wr high exactly 1 cycle at cycle 2, m_wait_rq[0] low at cycle 2.
REQ-035 Read with 2 slave wait states: m_rd[1], addr 0x04, slave returns 0x1234_5678 -> m_wait_rq[1] high for 3 cycles, then m_rd_data = 0x1234_5678 on the completion cycle.
REQ-036 Contention: masters 0 and 1 request together continuously, NUM_REQ=2 -> grants alternate 0,1,0,1 and master 1 sees m_wait_rq high throughout master 0's transaction.
REQ-037 Wrap-around: NUM_REQ=4, rr_ptr=3, requests from masters 0 and 3 -> grant 3 first, then 0.
REQ-038 Timeout (CSR_ARB_TIMEOUT_EN, TIMEOUT_CYC=8): slave holds wait high -> completion after 8 BUSY cycles, m_rd_data = 0xDEAD_BEEF, arb_err = 1 until reset.
REQ-039 Reset asserted in BUSY mid-read -> csr_rd = 0 in the same cycle, state IDLE, rr_ptr = 0.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types and constants for the CSR arbiter.
// Holds the arbiter state encoding and CSR bus widths.
package dma_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int CSR_ADDR_W = 32;
    localparam int CSR_DATA_W = 32;
    localparam logic [CSR_DATA_W-1:0] CSR_TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after
// the pointer, wrapping from N-1 back to 0.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [IW:0] slot;
    logic        found;

    always_comb begin
        idx_o = '0;
        found = 1'b0;
        slot  = '0;
        for (int k = 0; k < N; k++) begin
            slot = {1'b0, ptr_i} + (IW+1)'(k);
            if (slot >= (IW+1)'(N)) begin
                slot = slot - (IW+1)'(N);
            end
            if (!found && req_i[slot[IW-1:0]]) begin
                idx_o = slot[IW-1:0];
                found = 1'b1;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/csr_arb.sv
// Round-robin arbiter sharing one CSR slave port among NUM_REQ masters.
// Optional watchdog with forced completion: define CSR_ARB_TIMEOUT_EN.
module csr_arb
    import dma_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_REQ-1:0]                  m_wr,
    input  logic [NUM_REQ-1:0]                  m_rd,
    input  logic [NUM_REQ-1:0][CSR_ADDR_W-1:0]  m_addr,
    input  logic [NUM_REQ-1:0][CSR_DATA_W-1:0]  m_wr_data,
    output logic [NUM_REQ-1:0]                  m_wait_rq,
    output logic [CSR_DATA_W-1:0]               m_rd_data,
    output logic                                csr_wr,
    output logic                                csr_rd,
    output logic [CSR_ADDR_W-1:0]               csr_addr,
    output logic [CSR_DATA_W-1:0]               csr_wr_data,
    input  logic                                csr_wait_rq,
    input  logic [CSR_DATA_W-1:0]               csr_rd_data,
    output logic                                arb_err
);

    localparam int IW = $clog2(NUM_REQ);

    arb_state_t        state_q;
    logic [IW-1:0]     grant_q;
    logic [IW-1:0]     rr_ptr_q;
    logic [IW-1:0]     pick;
    logic              any_req;
    logic [NUM_REQ-1:0] req;
    logic              busy;
    logic              fwd_wr;
    logic              fwd_rd;
    logic              cmd;
    logic              tmo;
    logic              done;

    assign req    = m_wr | m_rd;
    assign busy   = (state_q == BUSY);
    // A simultaneous write and read from one master forwards only the write.
    assign fwd_wr = busy & m_wr[grant_q];
    assign fwd_rd = busy & m_rd[grant_q] & ~m_wr[grant_q];
    assign cmd    = fwd_wr | fwd_rd;
    assign done   = cmd & (~csr_wait_rq | tmo);

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req_i (req),
        .ptr_i (rr_ptr_q),
        .idx_o (pick),
        .any_o (any_req)
    );

`ifdef CSR_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt_q;
    logic          arb_err_q;

    assign tmo     = cmd & csr_wait_rq & (cnt_q == CW'(TIMEOUT_CYC - 1));
    assign arb_err = arb_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            arb_err_q <= 1'b0;
        end else begin
            if (!busy) begin
                cnt_q <= '0;
            end else if (cmd && csr_wait_rq && !tmo) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (done && tmo) begin
                arb_err_q <= 1'b1;
            end
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg = ^TIMEOUT_CYC;
    assign tmo        = 1'b0;
    assign arb_err    = 1'b0;
`endif

    always_comb begin
        csr_wr      = fwd_wr;
        csr_rd      = fwd_rd;
        csr_addr    = busy ? m_addr[grant_q] : '0;
        csr_wr_data = busy ? m_wr_data[grant_q] : '0;
        m_wait_rq   = req;
        if (busy) begin
            m_wait_rq[grant_q] = cmd & csr_wait_rq & ~tmo;
        end
        m_rd_data = '0;
        if (done && fwd_rd) begin
            m_rd_data = tmo ? CSR_TIMEOUT_DATA : csr_rd_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        grant_q <= pick;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    // A withdrawn request leaves the pointer untouched.
                    if (!cmd) begin
                        state_q <= IDLE;
                    end else if (done) begin
                        state_q  <= IDLE;
                        rr_ptr_q <= (grant_q == IW'(NUM_REQ - 1)) ?
                                    '0 : grant_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_arb.sv
// Self-checking bench for csr_arb: directed table, corner sequences,
// and randomized traffic against a behavioural model.
module tb_csr_arb;

    localparam int N  = 4;
    localparam int TO = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [N-1:0]         m_wr;
    logic [N-1:0]         m_rd;
    logic [N-1:0][31:0]   m_addr;
    logic [N-1:0][31:0]   m_wr_data;
    logic [N-1:0]         m_wait_rq;
    logic [31:0]          m_rd_data;
    logic                 csr_wr;
    logic                 csr_rd;
    logic [31:0]          csr_addr;
    logic [31:0]          csr_wr_data;
    logic                 csr_wait_rq;
    logic [31:0]          csr_rd_data;
    logic                 arb_err;

    csr_arb #(
        .NUM_REQ     (N),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .m_wr        (m_wr),
        .m_rd        (m_rd),
        .m_addr      (m_addr),
        .m_wr_data   (m_wr_data),
        .m_wait_rq   (m_wait_rq),
        .m_rd_data   (m_rd_data),
        .csr_wr      (csr_wr),
        .csr_rd      (csr_rd),
        .csr_addr    (csr_addr),
        .csr_wr_data (csr_wr_data),
        .csr_wait_rq (csr_wait_rq),
        .csr_rd_data (csr_rd_data),
        .arb_err     (arb_err)
    );

    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Behavioural model state
    bit    mb;
    int    mg, mp, mc;
    bit    me;
    logic  e_cwr, e_crd, e_cmd, e_tmo, e_done;
    logic [N-1:0] e_wait;
    logic [31:0]  e_rdata, e_addr, e_data;

    task automatic model_reset();
        mb = 0; mg = 0; mp = 0; mc = 0; me = 0;
    endtask

    task automatic model_eval();
        logic [N-1:0] rq;
        rq      = m_wr | m_rd;
        e_cwr   = 0; e_crd = 0; e_cmd = 0; e_tmo = 0; e_done = 0;
        e_wait  = rq; e_rdata = 0; e_addr = 0; e_data = 0;
        if (mb) begin
            e_cwr = m_wr[mg];
            e_crd = m_rd[mg] && !m_wr[mg];
            e_cmd = e_cwr || e_crd;
`ifdef CSR_ARB_TIMEOUT_EN
            e_tmo = e_cmd && csr_wait_rq && (mc == TO - 1);
`endif
            e_done     = e_cmd && (!csr_wait_rq || e_tmo);
            e_wait[mg] = e_cmd && csr_wait_rq && !e_tmo;
            if (e_done && e_crd)
                e_rdata = e_tmo ? 32'hDEAD_BEEF : csr_rd_data;
            e_addr = m_addr[mg];
            e_data = m_wr_data[mg];
        end
    endtask

    task automatic model_adv();
        logic [N-1:0] rq;
        rq = m_wr | m_rd;
        if (!mb) begin
            if (|rq) begin
                for (int k = N - 1; k >= 0; k--)
                    if (rq[(mp + k) % N]) mg = (mp + k) % N;
                mb = 1;
                mc = 0;
            end
        end else if (!e_cmd) begin
            mb = 0;
        end else if (e_done) begin
            mp = (mg + 1) % N;
            mb = 0;
            if (e_tmo) me = 1;
        end else if (csr_wait_rq) begin
            mc++;
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_eval();
        chk("rnd csr_wr", csr_wr, e_cwr);
        chk("rnd csr_rd", csr_rd, e_crd);
        chk("rnd m_wait_rq", m_wait_rq, e_wait);
        chk("rnd m_rd_data", m_rd_data, e_rdata);
        chk("rnd arb_err", arb_err, me);
        if (e_cmd) begin
            chk("rnd csr_addr", csr_addr, e_addr);
            chk("rnd csr_wr_data", csr_wr_data, e_data);
        end
        model_adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        m_wr = '0; m_rd = '0;
        csr_wait_rq = 1'b0; csr_rd_data = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset arb_err", arb_err, 0);
        chk("reset csr_wr", csr_wr, 0);
        chk("reset m_wait_rq", m_wait_rq, 0);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0]  wr;
        logic [3:0]  rd;
        logic        sw;
        logic [31:0] srd;
        logic        cwr;
        logic        crd;
        logic [3:0]  wt;
        logic [31:0] rdat;
        logic [31:0] addr;
        logic [31:0] wdat;
    } vec_t;

    vec_t tbl[17];
    bit   act[N];
    int   bias;
    int   g;

    initial begin
        tbl[0]  = '{4'h1, 4'h0, 0, 32'h0, 0, 0, 4'h1, 32'h0, 0, 0};
        tbl[1]  = '{4'h1, 4'h0, 0, 32'h0, 1, 0, 4'h0, 32'h0, 32'h10, 32'hA5A5_0001};
        tbl[2]  = '{4'h0, 4'h0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 0, 0};
        tbl[3]  = '{4'h0, 4'h2, 1, 32'h0, 0, 0, 4'h2, 32'h0, 0, 0};
        tbl[4]  = '{4'h0, 4'h2, 1, 32'h0, 0, 1, 4'h2, 32'h0, 32'h04, 0};
        tbl[5]  = '{4'h0, 4'h2, 1, 32'h0, 0, 1, 4'h2, 32'h0, 32'h04, 0};
        tbl[6]  = '{4'h0, 4'h2, 0, 32'h1234_5678, 0, 1, 4'h0, 32'h1234_5678, 32'h04, 0};
        tbl[7]  = '{4'h0, 4'h0, 0, 32'hFFFF_FFFF, 0, 0, 4'h0, 32'h0, 0, 0};
        tbl[8]  = '{4'h4, 4'h4, 0, 32'h5555, 0, 0, 4'h4, 32'h0, 0, 0};
        tbl[9]  = '{4'h4, 4'h4, 0, 32'h5555, 1, 0, 4'h0, 32'h0, 32'h20, 32'hA5A5_0003};
        tbl[10] = '{4'h0, 4'h8, 1, 32'h0, 0, 0, 4'h8, 32'h0, 0, 0};
        tbl[11] = '{4'h0, 4'h8, 1, 32'h0, 0, 1, 4'h8, 32'h0, 32'h30, 0};
        tbl[12] = '{4'h0, 4'h0, 1, 32'h0, 0, 0, 4'h0, 32'h0, 0, 0};
        tbl[13] = '{4'h9, 4'h0, 0, 32'h0, 0, 0, 4'h9, 32'h0, 0, 0};
        tbl[14] = '{4'h9, 4'h0, 0, 32'h0, 1, 0, 4'h1, 32'h0, 32'h30, 32'hA5A5_0004};
        tbl[15] = '{4'h1, 4'h0, 0, 32'h0, 0, 0, 4'h1, 32'h0, 0, 0};
        tbl[16] = '{4'h1, 4'h0, 0, 32'h0, 1, 0, 4'h0, 32'h0, 32'h10, 32'hA5A5_0001};

        m_addr[0] = 32'h10; m_addr[1] = 32'h04;
        m_addr[2] = 32'h20; m_addr[3] = 32'h30;
        for (int i = 0; i < N; i++) m_wr_data[i] = 32'hA5A5_0001 + i;

        do_reset();

        for (int i = 0; i < 17; i++) begin
            m_wr = tbl[i].wr;
            m_rd = tbl[i].rd;
            csr_wait_rq = tbl[i].sw;
            csr_rd_data = tbl[i].srd;
            @(negedge clk);
            chk($sformatf("row%0d csr_wr", i), csr_wr, tbl[i].cwr);
            chk($sformatf("row%0d csr_rd", i), csr_rd, tbl[i].crd);
            chk($sformatf("row%0d m_wait_rq", i), m_wait_rq, tbl[i].wt);
            chk($sformatf("row%0d m_rd_data", i), m_rd_data, tbl[i].rdat);
            if (tbl[i].cwr || tbl[i].crd)
                chk($sformatf("row%0d csr_addr", i), csr_addr, tbl[i].addr);
            if (tbl[i].cwr)
                chk($sformatf("row%0d csr_wr_data", i), csr_wr_data, tbl[i].wdat);
            @(posedge clk);
            #1;
        end
        m_wr = '0; m_rd = '0; csr_wait_rq = 0;
        @(posedge clk);
        #1;

`ifdef CSR_ARB_TIMEOUT_EN
        m_rd = 4'h4;
        csr_wait_rq = 1'b1;
        csr_rd_data = 32'h0BAD_0BAD;
        @(negedge clk);
        chk("tmo idle wait", m_wait_rq, 4'h4);
        @(posedge clk);
        #1;
        for (int b = 0; b < TO; b++) begin
            @(negedge clk);
            chk($sformatf("tmo b%0d wait", b), m_wait_rq[2], b < TO - 1);
            chk($sformatf("tmo b%0d rdata", b), m_rd_data,
                (b == TO - 1) ? 32'hDEAD_BEEF : 32'h0);
            chk($sformatf("tmo b%0d err", b), arb_err, 0);
            @(posedge clk);
            #1;
        end
        m_rd = '0;
        csr_wait_rq = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("tmo sticky err", arb_err, 1);
            chk("tmo after wait", m_wait_rq, 0);
            @(posedge clk);
            #1;
        end
`endif

        do_reset();
        m_wr = 4'h3;
        for (int t = 0; t < 5; t++) begin
            g = t % 2;
            @(negedge clk);
            chk($sformatf("cont%0d idle wait", t), m_wait_rq, 4'h3);
            chk($sformatf("cont%0d idle wr", t), csr_wr, 0);
            @(posedge clk);
            #1;
            @(negedge clk);
            chk($sformatf("cont%0d busy wr", t), csr_wr, 1);
            chk($sformatf("cont%0d addr", t), csr_addr, m_addr[g]);
            chk($sformatf("cont%0d wait", t), m_wait_rq,
                (g == 0) ? 4'h2 : 4'h1);
            @(posedge clk);
            #1;
        end

        m_wr = '0;
        m_rd = 4'h2;
        csr_wait_rq = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        chk("rst mid csr_rd before", csr_rd, 1);
        reset = 1'b1;
        #1;
        chk("rst mid csr_rd", csr_rd, 0);
        chk("rst mid wait", m_wait_rq, 4'h2);
        @(posedge clk);
        #1 reset = 1'b0;
        m_rd = '0;
        m_wr = 4'h3;
        csr_wait_rq = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst ptr grant0 wait", m_wait_rq, 4'h2);
        chk("rst ptr addr", csr_addr, 32'h10);
        @(posedge clk);
        #1;

        do_reset();
        model_reset();
        for (int i = 0; i < N; i++) act[i] = 0;
        bias = 1;
        for (int c = 0; c < 800; c++) begin
            if (c % 60 == 0) bias = $urandom_range(0, 3);
            csr_wait_rq = ($urandom_range(0, 99) < bias * 34);
            csr_rd_data = $urandom;
            step();
            for (int i = 0; i < N; i++) begin
                if (act[i] && !e_wait[i]) act[i] = 0;
                else if (act[i] && $urandom_range(0, 49) == 0) act[i] = 0;
                if (!act[i]) begin
                    m_wr[i] = 1'b0;
                    m_rd[i] = 1'b0;
                    if ($urandom_range(0, 2) == 0) begin
                        int k;
                        k = $urandom_range(0, 2);
                        act[i] = 1;
                        m_wr[i] = (k != 1);
                        m_rd[i] = (k != 0);
                        m_addr[i] = $urandom;
                        m_wr_data[i] = $urandom;
                    end
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
